// File: rtl/agc_arith_cnt.sv
// Arithmetic register file with an end-around-carry adder, plus NCHAN ones'-complement
// counters fed by up/down request pulses and serviced one per granted slot, round-robin.
module agc_arith_cnt #(
  parameter  int WIDTH = 16,
  parameter  int NCHAN = 3,
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic [WIDTH-1:0] WL,
  input  logic [3:0]       wsel,
  input  logic [2:0]       rsel,
  input  logic [CW-1:0]    csel,
  input  logic [1:0]       gmode,
  input  logic             CI,
  input  logic             EACEN,
  input  logic [NCHAN-1:0] cnt_up,
  input  logic [NCHAN-1:0] cnt_dn,
  input  logic             cnt_slot,
  output logic [WIDTH-1:0] RL,
  output logic [WIDTH-1:0] U,
  output logic             CO,
  output logic             OVF,
  output logic [NCHAN-1:0] cnt_ovf,
  output logic [NCHAN-1:0] cnt_unf,
  output logic             cnt_lost,
  output logic             cnt_busy
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] a_r, l_r, q_r, z_r, g_r, x_r, y_r;
  logic [WIDTH-1:0] cnt_r [NCHAN];
  logic [NCHAN-1:0] pup, pdn;
  logic [CW-1:0]    ptr;

  // Adder: end-around carry folds CO back into the low bit when enabled.
  logic [WIDTH:0] sum;
  assign sum      = {1'b0, x_r} + {1'b0, y_r} + {{WIDTH{1'b0}}, CI};
  assign CO       = sum[WIDTH];
  assign U        = sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, EACEN & CO};
  assign OVF      = U[WIDTH-1] ^ U[WIDTH-2];
  assign cnt_busy = |(pup | pdn);

  logic [WIDTH-1:0] g_next;
  always_comb begin
    g_next = WL;
    case (gmode)
      2'd1:    g_next = {WL[0], WL[WIDTH-1:1]};
      2'd2:    g_next = {WL[WIDTH-1], WL[WIDTH-1:1]};
      2'd3:    g_next = {WL[WIDTH-2:0], WL[WIDTH-1]};
      default: g_next = WL;
    endcase
  end

  logic [WIDTH-1:0] cnt_rd;
  logic [WIDTH-1:0] rl_mux;
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NCHAN; i++)
      if (csel == CW'(i)) cnt_rd = cnt_r[i];
    rl_mux = '0;
    case (rsel)
      3'd1:    rl_mux = a_r;
      3'd2:    rl_mux = l_r;
      3'd3:    rl_mux = q_r;
      3'd4:    rl_mux = z_r;
      3'd5:    rl_mux = g_r;
      3'd6:    rl_mux = U;
      3'd7:    rl_mux = cnt_rd;
      default: rl_mux = '0;
    endcase
  end
  assign RL = rst ? rl_mux : '0;

  // Request handshake: cnt_up/cnt_dn are single-cycle pulses latched into pup/pdn;
  // cnt_slot grants at most one service per edge to a channel holding exactly one flag.
  logic             srv_hit;
  logic [CW-1:0]    srv_idx;
  int               c;
  always_comb begin
    srv_hit = 1'b0;
    srv_idx = '0;
    c       = 0;
    for (int k = 0; k < NCHAN; k++) begin
      c = (int'(ptr) + k) % NCHAN;
      if (!srv_hit && cnt_slot && (pup[c] ^ pdn[c])) begin
        srv_hit = 1'b1;
        srv_idx = CW'(c);
      end
    end
  end

  logic             host_cnt_wr;
  logic             do_srv;
  logic [NCHAN-1:0] srv_mask;
  logic [NCHAN-1:0] cancel, clr_up, clr_dn;
  logic             srv_is_up;
  logic [WIDTH-1:0] srv_cur, srv_val;
  logic             srv_ovf, srv_unf;

  assign host_cnt_wr = (wsel == 4'd8);
  // A host write to the channel being serviced wins; the service is abandoned.
  assign do_srv      = srv_hit && !(host_cnt_wr && csel == srv_idx);
  assign srv_mask    = do_srv ? (NCHAN'(1) << srv_idx) : '0;
  assign cancel      = pup & pdn;
  assign clr_up      = cancel | (srv_mask & pup);
  assign clr_dn      = cancel | (srv_mask & pdn);
  assign srv_is_up   = |(srv_mask & pup);

  always_comb begin
    srv_cur = '0;
    for (int i = 0; i < NCHAN; i++)
      if (srv_idx == CW'(i)) srv_cur = cnt_r[i];
    srv_ovf = 1'b0;
    srv_unf = 1'b0;
    if (srv_is_up) begin
      if (srv_cur == MAX_POS) begin
        srv_val = ZERO;
        srv_ovf = 1'b1;
      end else if (srv_cur == ONES) begin
        srv_val = {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        srv_val = srv_cur + 1'b1;
      end
    end else begin
      if (srv_cur == MAX_NEG) begin
        srv_val = ONES;
        srv_unf = 1'b1;
      end else if (srv_cur == ZERO) begin
        srv_val = {{(WIDTH-1){1'b1}}, 1'b0};
      end else begin
        srv_val = srv_cur - 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      a_r <= '0; l_r <= '0; q_r <= '0; z_r <= '0;
      g_r <= '0; x_r <= '0; y_r <= '0;
      for (int i = 0; i < NCHAN; i++) cnt_r[i] <= '0;
      pup      <= '0;
      pdn      <= '0;
      ptr      <= '0;
      cnt_ovf  <= '0;
      cnt_unf  <= '0;
      cnt_lost <= 1'b0;
    end else begin
      case (wsel)
        4'd1:    a_r <= WL;
        4'd2:    l_r <= WL;
        4'd3:    q_r <= WL;
        4'd4:    z_r <= WL;
        4'd5:    g_r <= g_next;
        4'd6:    x_r <= WL;
        4'd7:    y_r <= WL;
        default: ;
      endcase
      for (int i = 0; i < NCHAN; i++) begin
        if (host_cnt_wr && csel == CW'(i))
          cnt_r[i] <= WL;
        else if (srv_mask[i])
          cnt_r[i] <= srv_val;
      end
      // A fresh pulse on a flag cleared this edge re-sets it rather than being lost.
      pup      <= (pup & ~clr_up) | cnt_up;
      pdn      <= (pdn & ~clr_dn) | cnt_dn;
      cnt_lost <= |((cnt_up & pup & ~clr_up) | (cnt_dn & pdn & ~clr_dn));
      cnt_ovf  <= srv_ovf ? srv_mask : '0;
      cnt_unf  <= srv_unf ? srv_mask : '0;
      if (do_srv)
        ptr <= (int'(srv_idx) == NCHAN - 1) ? '0 : srv_idx + 1'b1;
    end
  end

endmodule

// File: doc/agc_arith_cnt.md
AGC_ARITH_CNT -- requirements
Module: agc_arith_cnt

Interface
REQ-001 Parameter WIDTH, default 16, sets the word width (>=4) of all registers, buses and counters.
REQ-002 Parameter NCHAN, default 3, sets the number of counter channels (>=1); CW = max(1, clog2(NCHAN)).
REQ-003 CLOCK  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 WL  in  WIDTH  write bus.
REQ-006 wsel  in  4  write target: 0 none, 1 A, 2 L, 3 Q, 4 Z, 5 G, 6 X, 7 Y, 8 counter[csel], 9-15 none.
REQ-007 rsel  in  3  read source: 0 none, 1 A, 2 L, 3 Q, 4 Z, 5 G, 6 U (adder sum), 7 counter[csel].
REQ-008 csel  in  CW  counter index for read/write; an index >= NCHAN reads 0 and ignores writes.
REQ-009 gmode  in  2  G write editing: 0 straight, 1 cycle right, 2 shift right sign-preserving, 3 cycle left.
REQ-010 CI  in  1  adder carry-in.   EACEN  in  1  end-around-carry enable.
REQ-011 cnt_up, cnt_dn  in  NCHAN  one-cycle increment/decrement request pulses per channel.
REQ-012 cnt_slot  in  1  grants one counter service this cycle.
REQ-013 RL  out  WIDTH  read bus.   U  out  WIDTH  adder sum.   CO  out  1  adder carry out of MSB.   OVF  out  1  sign-overflow.
REQ-014 cnt_ovf, cnt_unf  out  NCHAN  per-channel overflow/underflow pulses.   cnt_lost  out  1  dropped-request pulse.   cnt_busy  out  1  any request pending.

Function
REQ-015 A write updates the selected register at the rising edge; other registers hold.
REQ-016 RL is combinational from the selected source and is 0 when rsel=0; a same-cycle read of a register being written returns its pre-edge value.
REQ-017 The adder is combinational: S = X + Y + CI over WIDTH+1 bits; CO = S[WIDTH]; U = S[WIDTH-1:0] + (EACEN & CO), truncated to WIDTH bits.
REQ-018 OVF = U[WIDTH-1] XOR U[WIDTH-2], combinational.
REQ-019 gmode on write to G: 1 gives G = {WL[0], WL[W-1:1]}; 2 gives G = {WL[W-1], WL[W-1:1]}; 3 gives G = {WL[W-2:0], WL[W-1]}; gmode is ignored for all other targets.
REQ-020 Each channel has registered flags pup and pdn; a cnt_up/cnt_dn pulse sets the corresponding flag at the next edge.
REQ-021 A pulse arriving while its flag is already set and not being cleared at that edge is dropped, and cnt_lost pulses high for exactly one cycle after that edge.
REQ-022 If pup and pdn are both set on a channel, both clear at the next edge with no counter change; cancel has priority over service.
REQ-023 On an edge with cnt_slot=1, the arbiter services exactly one channel with exactly one flag set, chosen round-robin starting at pointer ptr; ptr then becomes (served+1) mod NCHAN; with no eligible channel, nothing changes.
REQ-024 Service arithmetic is ones'-complement on counter C:
  - up: C=011..1 gives 000..0 and a cnt_ovf pulse; C=111..1 gives 000..01; otherwise C+1.
  - down: C=100..0 gives 111..1 and a cnt_unf pulse; C=000..0 gives 111..10; otherwise C-1.
  - The serviced flag clears.
REQ-025 cnt_ovf and cnt_unf are registered and high for exactly the one cycle following the service edge.
REQ-026 A new pulse on the flag being cleared at that same edge leaves the flag set; the set wins and nothing is lost.
REQ-027 A host write (wsel=8) and a service to the same counter at the same edge: the host write wins, the counter takes WL, and the flag stays set.
REQ-028 cnt_busy = OR of all pup/pdn flags, from registered state.

Reset
REQ-029 While rst=0, the following are 0: A, L, Q, Z, G, X, Y, all counters, all flags, ptr, cnt_ovf, cnt_unf, cnt_lost; RL is 0 and inputs are ignored.
REQ-030 Deasserting reset mid-operation discards all pending requests; the first edge after release behaves as the first cycle after power-up.

Verification (WIDTH=16, NCHAN=3)
REQ-031 X=FFFE, Y=0003, CI=0, EACEN=1 -> U=0002, CO=1; same with EACEN=0 -> U=0001.
REQ-032 X=4000, Y=4000 -> U=8000, OVF=1, CO=0; rsel=6 -> RL=8000.
REQ-033 Writes to G with WL=0003 gmode=1 -> G=8001; WL=8004 gmode=2 -> G=C002; WL=8001 gmode=3 -> G=0003.
REQ-034 Counter1 preset to 7FFF, cnt_up[1] pulse, then cnt_slot=1 -> counter1=0000, cnt_ovf[1] high for one cycle; counter2=0000 with cnt_dn[2] serviced -> FFFE, no cnt_unf.
REQ-035 cnt_up[0] and cnt_dn[0] in the same cycle -> counter0 unchanged, cnt_busy returns to 0; two cnt_up[0] pulses before any slot -> cnt_lost pulses once and counter0 advances by 1.
REQ-036 Flags set on all three channels, cnt_slot held high -> service order 0,1,2; rst pulsed low mid-sequence -> all counters, flags and RL read 0.
